// File: rtl/max_pool_layer.sv
`default_nettype none
// ============================================================================
// Module      : max_pool_layer
// Description : Streaming PxP max-pool with stride P over a raster-ordered,
//               multi-channel signed feature map. Each pooled maximum is
//               post-processed per channel: optional ReLU, arithmetic right
//               shift, then saturation to WidthOut bits.
// Ports       : clk_i    - clock
//               rst_i    - synchronous active-high reset
//               valid_i  - input pixel valid
//               ready_o  - input ready (~valid_o | ready_i)
//               data_i   - input pixel, all channels, signed WidthIn each
//               valid_o  - pooled output valid
//               ready_i  - downstream ready
//               data_o   - pooled output, all channels, signed WidthOut each
// Revision    : 1.0 - initial release
// ============================================================================
module max_pool_layer #(
    parameter int LineWidthPx = 158,
    parameter int LineCountPx = 118,
    parameter int Channels    = 2,
    parameter int WidthIn     = 32,
    parameter int WidthOut    = 8,
    parameter int PoolSize    = 2,
    parameter int ReluEn      = 1,
    parameter int Shift       = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic [Channels-1:0][WidthIn-1:0]     data_i,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [Channels-1:0][WidthOut-1:0]    data_o
);

    localparam int C_POOL_W = LineWidthPx / PoolSize;
    localparam int C_POOL_H = LineCountPx / PoolSize;
    localparam int XW       = $clog2(LineWidthPx + 1);
    localparam int YW       = $clog2(LineCountPx + 1);
    localparam int PW       = $clog2(PoolSize + 1);
    localparam int AW       = (C_POOL_W > 1) ? $clog2(C_POOL_W) : 1;

    localparam logic [XW-1:0] C_X_LAST = XW'(LineWidthPx - 1);
    localparam logic [YW-1:0] C_Y_LAST = YW'(LineCountPx - 1);
    localparam logic [XW-1:0] C_X_ACT  = XW'(C_POOL_W * PoolSize);
    localparam logic [YW-1:0] C_Y_ACT  = YW'(C_POOL_H * PoolSize);
    localparam logic [PW-1:0] C_P_LAST = PW'(PoolSize - 1);

    localparam logic signed [WidthIn-1:0] C_SAT_MAX =
        {{(WidthIn-WidthOut+1){1'b0}}, {(WidthOut-1){1'b1}}};
    localparam logic signed [WidthIn-1:0] C_SAT_MIN =
        {{(WidthIn-WidthOut+1){1'b1}}, {(WidthOut-1){1'b0}}};

    logic [XW-1:0] r_x_pos;
    logic [YW-1:0] r_y_pos;
    logic [PW-1:0] r_xp;
    logic [PW-1:0] r_yp;
    logic [XW-1:0] r_px;

    logic          w_fire;
    logic          w_active;
    logic          w_xp_first;
    logic          w_xp_last;
    logic          w_yp_first;
    logic          w_yp_last;
    logic          w_produce;
    logic [AW-1:0] w_idx;
    logic [Channels-1:0][WidthOut-1:0] w_post;

    assign ready_o    = ~valid_o | ready_i;
    assign w_fire     = valid_i & ready_o;
    // Pixels in the trailing partial columns/rows never contribute to a window.
    assign w_active   = (r_x_pos < C_X_ACT) && (r_y_pos < C_Y_ACT);
    assign w_xp_first = (r_xp == '0);
    assign w_xp_last  = (r_xp == C_P_LAST);
    assign w_yp_first = (r_yp == '0);
    assign w_yp_last  = (r_yp == C_P_LAST);
    assign w_produce  = w_fire & w_active & w_xp_last & w_yp_last;
    assign w_idx      = r_px[AW-1:0];

    // Raster position plus window phase / pooled column counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x_pos <= '0;
            r_y_pos <= '0;
            r_xp    <= '0;
            r_yp    <= '0;
            r_px    <= '0;
        end else if (w_fire) begin
            if (r_x_pos == C_X_LAST) begin
                r_x_pos <= '0;
                r_xp    <= '0;
                r_px    <= '0;
                if (r_y_pos == C_Y_LAST) begin
                    r_y_pos <= '0;
                    r_yp    <= '0;
                end else begin
                    r_y_pos <= r_y_pos + 1'b1;
                    r_yp    <= w_yp_last ? '0 : r_yp + 1'b1;
                end
            end else begin
                r_x_pos <= r_x_pos + 1'b1;
                r_xp    <= w_xp_last ? '0 : r_xp + 1'b1;
                if (w_xp_last) begin
                    r_px <= r_px + 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < Channels; c++) begin : g_ch
        logic signed [WidthIn-1:0] w_din;
        logic signed [WidthIn-1:0] w_m;
        logic signed [WidthIn-1:0] w_rd;
        logic signed [WidthIn-1:0] w_res;
        logic signed [WidthIn-1:0] w_relu;
        logic signed [WidthIn-1:0] w_shr;
        logic signed [WidthIn-1:0] r_hmax;
        // Per-column vertical running maxima; contents are don't-care after
        // reset because row phase 0 overwrites every entry it reads.
        logic signed [WidthIn-1:0] r_lbuf [C_POOL_W];

        assign w_din = $signed(data_i[c]);
        assign w_rd  = r_lbuf[w_idx];
        assign w_m   = (w_din > r_hmax) ? w_din : r_hmax;
        assign w_res = (w_rd > w_m) ? w_rd : w_m;

        assign w_relu = ((ReluEn != 0) && (w_res < 0)) ? '0 : w_res;
        assign w_shr  = w_relu >>> Shift;
        assign w_post[c] = (w_shr > C_SAT_MAX) ? C_SAT_MAX[WidthOut-1:0] :
                           (w_shr < C_SAT_MIN) ? C_SAT_MIN[WidthOut-1:0] :
                                                 w_shr[WidthOut-1:0];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_hmax <= '0;
            end else if (w_fire && w_active) begin
                r_hmax <= w_xp_first ? w_din : w_m;
            end
        end

        // Read happens combinationally before this registered write, so the
        // read always sees the pre-write value at the shared index.
        always_ff @(posedge clk_i) begin
            if (w_fire && w_active && w_xp_last && !w_yp_last) begin
                r_lbuf[w_idx] <= w_yp_first ? w_m : w_res;
            end
        end
    end

    // Single-entry elastic output stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (ready_o) begin
            valid_o <= w_produce;
            if (w_produce) begin
                data_o <= w_post;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_max_pool_layer.sv
`default_nettype none
// ============================================================================
// Module      : tb_max_pool_layer
// Description : Self-checking bench for max_pool_layer. Two instances:
//               dut 0 = 4x4 map, ReLU off, shift 0;
//               dut 1 = 5x5 map, ReLU on,  shift 2.
//               Expected window results are queued as the bottom-right pixel
//               of each window is accepted and compared when output handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max_pool_layer;

    logic                  clk;
    logic                  rst;
    logic                  v_in  [2];
    logic                  r_out [2];
    logic [1:0][31:0]      d_in  [2];
    logic                  v_out [2];
    logic                  r_in  [2];
    logic [1:0][7:0]       d_out [2];

    int cfg_w    [2] = '{4, 5};
    int cfg_h    [2] = '{4, 5};
    int cfg_relu [2] = '{0, 1};
    int cfg_sh   [2] = '{0, 2};

    int          n_total = 0;
    int          n_bad   = 0;
    int          cur     = 0;
    bit          rand_mode = 0;
    int          cyc     = 0;
    int          lat_cyc = -1;
    logic [15:0] q [$];
    int          img [0:4][0:4][0:1];
    bit          prev_stall = 0;
    logic [15:0] prev_data  = '0;

    max_pool_layer #(
        .LineWidthPx(4), .LineCountPx(4), .Channels(2), .WidthIn(32),
        .WidthOut(8), .PoolSize(2), .ReluEn(0), .Shift(0)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst), .valid_i(v_in[0]), .ready_o(r_out[0]),
        .data_i(d_in[0]), .valid_o(v_out[0]), .ready_i(r_in[0]),
        .data_o(d_out[0])
    );

    max_pool_layer #(
        .LineWidthPx(5), .LineCountPx(5), .Channels(2), .WidthIn(32),
        .WidthOut(8), .PoolSize(2), .ReluEn(1), .Shift(2)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(v_in[1]), .ready_o(r_out[1]),
        .data_i(d_in[1]), .valid_o(v_out[1]), .ready_i(r_in[1]),
        .data_o(d_out[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] post(input int v, input int relu, input int sh);
        int t;
        t = v;
        if (relu != 0 && t < 0) t = 0;
        t = t >>> sh;
        if (t > 127)  t = 127;
        if (t < -128) t = -128;
        return t[7:0];
    endfunction

    // Downstream ready: random for the active instance in random mode.
    initial begin
        r_in[0] = 1'b1;
        r_in[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                r_in[i] = (rand_mode && i == cur) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (cyc == lat_cyc) chk("latency", 32'(v_out[cur]), 32'd1);
            if (prev_stall) chk("hold", 32'(d_out[cur]), 32'(prev_data));
            if (v_out[cur] && r_in[cur]) begin
                if (q.size() == 0) chk("extra_out", 32'd1, 32'd0);
                else chk("out", 32'(d_out[cur]), 32'(q.pop_front()));
            end
            prev_stall = v_out[cur] && !r_in[cur];
            prev_data  = d_out[cur];
        end
    end

    task automatic drive_pixel(input int d0, input int d1, input bit br, input logic [15:0] ev);
        int t;
        t = 0;
        v_in[cur] = 1'b1;
        d_in[cur] = {d1, d0};
        do begin
            @(negedge clk);
            t++;
        end while (!r_out[cur] && t < 1000);
        if (!r_out[cur]) begin
            chk("in_timeout", 32'd0, 32'd1);
            $display("test done: total=%0d bad=%0d", n_total, n_bad);
            $fatal(1, "input stalled");
        end
        if (br) begin
            q.push_back(ev);
            if (!rand_mode) lat_cyc = cyc + 1;
        end
        @(posedge clk);
        #1;
        v_in[cur] = 1'b0;
    endtask

    task automatic drive_frame(input int npix);
        int w, h, m0, m1;
        bit br;
        logic [15:0] ev;
        w = cfg_w[cur];
        h = cfg_h[cur];
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (y * w + x >= npix) return;
                if (rand_mode) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                br = (x % 2 == 1) && (y % 2 == 1) && (x < (w / 2) * 2) && (y < (h / 2) * 2);
                ev = '0;
                if (br) begin
                    m0 = img[y-1][x-1][0];
                    m1 = img[y-1][x-1][1];
                    for (int dy = -1; dy <= 0; dy++)
                        for (int dx = -1; dx <= 0; dx++) begin
                            if (img[y+dy][x+dx][0] > m0) m0 = img[y+dy][x+dx][0];
                            if (img[y+dy][x+dx][1] > m1) m1 = img[y+dy][x+dx][1];
                        end
                    ev = {post(m1, cfg_relu[cur], cfg_sh[cur]), post(m0, cfg_relu[cur], cfg_sh[cur])};
                end
                drive_pixel(img[y][x][0], img[y][x][1], br, ev);
            end
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && q.size() != 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("drain_empty", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(v_out[cur]), 32'd0);
        chk("rst_data",  32'(d_out[cur]), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int mode);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++) begin
                case (mode)
                    0: begin
                        img[y][x][0] = y * cfg_w[cur] + x;
                        img[y][x][1] = -(y * cfg_w[cur] + x);
                    end
                    1: begin
                        img[y][x][0] = x * 10 + y;
                        img[y][x][1] = -300;
                    end
                    2: begin
                        img[y][x][0] = int'($urandom_range(0, 800)) - 400;
                        img[y][x][1] = int'($urandom_range(0, 800)) - 400;
                    end
                    default: begin
                        img[y][x][0] = 100 - x - y;
                        img[y][x][1] = x * y;
                        if (x == 4 || y == 4) begin
                            img[y][x][0] = 9999;
                            img[y][x][1] = 9999;
                        end
                    end
                endcase
            end
        if (mode == 1) img[1][1][0] = 300;
        if (mode == 3) img[1][1][1] = 515;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            v_in[i] = 1'b0;
            d_in[i] = '0;
        end
        cur = 0;
        do_reset();
        chk("rst_valid1", 32'(v_out[1]), 32'd0);

        // 4x4 raster index: 5,7,13,15 / 0,-2,-8,-10
        fill(0);
        drive_frame(16);
        drain();

        // saturation: max 300 -> 127, all -300 -> -128
        fill(1);
        drive_frame(16);
        drain();

        // reset after 6 pixels, then full frame
        fill(0);
        drive_frame(6);
        drain();
        do_reset();
        drive_frame(16);
        drain();

        // random valid/ready over 3 frames
        rand_mode = 1;
        for (int f = 0; f < 3; f++) begin
            fill(2);
            drive_frame(16);
        end
        drain();
        rand_mode = 0;
        drain();

        // 5x5 with ReLU and shift 2: trailing row/column ignored
        cur = 1;
        fill(0);
        drive_frame(25);
        drain();
        drive_frame(25);
        drain();
        fill(3);
        drive_frame(25);
        drain();

        chk("final_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
